mod_exp_engine: RTL and testbench

- Sequential modular exponentiation unit: r = g^e mod p, by right-to-left binary square-and-multiply.
- Sits directly upstream of the public-value and shared-key paths.
- Produces the r1/r2 public values (g^x mod p, g^y mod p) and the shared-key exponentiation consumed by the encryption/check stages.
- One instance per party; start/done handshake.

---
 rtl/mod_exp_pkg.sv | 32 +++
 rtl/mod_mul_seq.sv | 84 ++++++++
 rtl/mod_exp_engine.sv | 207 ++++++++++++++++++++
 tb/tb_mod_exp_engine.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mod_exp_pkg.sv
// ============================================================================
// Module   : mod_exp_pkg
// Purpose  : Shared types and constants for the modular exponentiation engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mod_exp_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [DEFAULT_WIDTH-1:0] c_ONE = DEFAULT_WIDTH'(1);

    function automatic int step_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int STEP_W = step_width(DEFAULT_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_REDUCE = 3'd2,
        S_MUL    = 3'd3,
        S_SQR    = 3'd4,
        S_NEXT   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mod_mul_seq.sv
// ============================================================================
// Module   : mod_mul_seq
// Purpose  : Sequential a*b mod p, interleaved shift-add, b scanned MSB-first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mod_mul_seq
    import mod_exp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic             done,
    output logic [WIDTH-1:0] r
);

    localparam int TW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_p;
    logic [TW-1:0]    r_t;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [TW-1:0] w_pe;
    logic [TW-1:0] w_dbl;
    logic [TW-1:0] w_red1;
    logic [TW-1:0] w_add;
    logic [TW-1:0] w_red2;

    // Two guard bits keep 2*t and t+a (both below 2p) from overflowing at full width.
    always_comb begin
        w_pe   = {2'b00, r_p};
        w_dbl  = r_t << 1;
        w_red1 = (w_dbl >= w_pe) ? (w_dbl - w_pe) : w_dbl;
        w_add  = r_b[WIDTH-1] ? (w_red1 + {2'b00, r_a}) : w_red1;
        w_red2 = (w_add >= w_pe) ? (w_add - w_pe) : w_add;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_p    <= '0;
            r_t    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_a    <= a;
                r_b    <= b;
                r_p    <= p;
                r_t    <= '0;
                r_cnt  <= CW'(WIDTH);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_t   <= w_red2;
                r_b   <= r_b << 1;
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done = r_done;
    assign r    = r_t[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/mod_exp_engine.sv
// ============================================================================
// Module   : mod_exp_engine
// Purpose  : r = g^e mod p, right-to-left square-and-multiply, start/done
//            handshake. MODEXP_CT_EN selects constant-time operation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mod_exp_engine
    import mod_exp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] e,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] r
);

    localparam int               CNT_W   = step_width(WIDTH);
    localparam logic [CNT_W-1:0] c_STEPS = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] c_UNIT  = WIDTH'(c_ONE);

    state_t           r_state;
    logic [WIDTH-1:0] r_g;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_e;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_base;
    logic [CNT_W-1:0] r_step;
    logic             r_wait;
    logic             r_mm_start;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [WIDTH-1:0] r_res;

    logic [WIDTH-1:0] w_mm_a;
    logic [WIDTH-1:0] w_mm_b;
    logic [WIDTH-1:0] w_mm_r;
    logic             w_mm_done;

    // REDUCE computes 1*g so that an unreduced base still satisfies a < p.
    always_comb begin
        w_mm_a = r_base;
        w_mm_b = r_base;
        case (r_state)
            S_REDUCE: begin
                w_mm_a = c_UNIT;
                w_mm_b = r_g;
            end
            S_MUL: begin
                w_mm_a = r_acc;
                w_mm_b = r_base;
            end
            default: ;
        endcase
    end

    mod_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (r_mm_start),
        .a     (w_mm_a),
        .b     (w_mm_b),
        .p     (r_p),
        .done  (w_mm_done),
        .r     (w_mm_r)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_g        <= '0;
            r_p        <= '0;
            r_e        <= '0;
            r_acc      <= '0;
            r_base     <= '0;
            r_step     <= '0;
            r_wait     <= 1'b0;
            r_mm_start <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_res      <= '0;
        end else begin
            r_mm_start <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (st) begin
                        r_g     <= g;
                        r_p     <= p;
                        r_e     <= e;
                        r_step  <= '0;
                        r_wait  <= 1'b0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
`ifdef MODEXP_CT_EN
                    // Degenerate moduli still run the full schedule; result is overridden at the end.
                    r_acc   <= c_UNIT;
                    r_state <= S_REDUCE;
`else
                    if (r_p <= c_UNIT) begin
                        r_res   <= '0;
                        r_err   <= (r_p == '0);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_acc   <= c_UNIT;
                        r_state <= S_REDUCE;
                    end
`endif
                end
                S_REDUCE: begin
                    if (!r_wait) begin
                        r_mm_start <= 1'b1;
                        r_wait     <= 1'b1;
                    end else if (w_mm_done) begin
                        r_wait  <= 1'b0;
                        r_base  <= w_mm_r;
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
`ifdef MODEXP_CT_EN
                    if (r_step == c_STEPS) begin
                        r_res   <= (r_p <= c_UNIT) ? '0 : r_acc;
                        r_err   <= (r_p == '0);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_MUL;
                    end
`else
                    if (r_e == '0) begin
                        r_res   <= r_acc;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_e[0]) begin
                        r_state <= S_MUL;
                    end else begin
                        r_state <= S_SQR;
                    end
`endif
                end
                S_MUL: begin
                    if (!r_wait) begin
                        r_mm_start <= 1'b1;
                        r_wait     <= 1'b1;
                    end else if (w_mm_done) begin
                        r_wait <= 1'b0;
`ifdef MODEXP_CT_EN
                        if (r_e[0]) begin
                            r_acc <= w_mm_r;
                        end
`else
                        r_acc <= w_mm_r;
`endif
                        r_state <= S_SQR;
                    end
                end
                S_SQR: begin
                    if (!r_wait) begin
                        r_mm_start <= 1'b1;
                        r_wait     <= 1'b1;
                    end else if (w_mm_done) begin
                        r_wait  <= 1'b0;
                        r_base  <= w_mm_r;
                        r_e     <= r_e >> 1;
                        r_step  <= r_step + 1'b1;
                        r_state <= S_NEXT;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;
    assign r    = r_res;

endmodule

`default_nettype wire

// File: tb/tb_mod_exp_engine.sv
// ============================================================================
// Module   : tb_mod_exp_engine
// Purpose  : Directed, table-driven self-checking bench for mod_exp_engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mod_exp_engine;

    localparam int W     = 32;
    localparam int BOUND = 6000;

    logic         clk;
    logic         rst;
    logic         st;
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] e;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] r;

    int tests;
    int fails;

    typedef struct {
        logic [W-1:0] g;
        logic [W-1:0] p;
        logic [W-1:0] e;
        logic [W-1:0] r;
        logic         err;
    } vec_t;

    vec_t vecs[10];

    mod_exp_engine #(
        .WIDTH (W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .st   (st),
        .g    (g),
        .p    (p),
        .e    (e),
        .busy (busy),
        .done (done),
        .err  (err),
        .r    (r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input logic [W-1:0] ig, input logic [W-1:0] ip, input logic [W-1:0] ie,
                       input bit mid_st, output logic [W-1:0] or_, output logic oerr,
                       output int cyc);
        bit busy_bad;
        @(negedge clk);
        g  = ig;
        p  = ip;
        e  = ie;
        st = 1'b1;
        @(negedge clk);
        st       = 1'b0;
        g        = $urandom;
        p        = $urandom;
        e        = $urandom;
        cyc      = 0;
        busy_bad = 1'b0;
        while (!done && cyc < BOUND) begin
            if (!busy) busy_bad = 1'b1;
            st = (mid_st && cyc == 40);
            @(negedge clk);
            cyc++;
        end
        st = 1'b0;
        check("done_within_bound", {31'd0, done}, 32'd1);
        check("busy_during_op", {31'd0, busy_bad}, 32'd0);
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
        or_  = r;
        oerr = err;
    endtask

`ifdef MODEXP_CT_EN
    function automatic logic [W-1:0] model(input logic [W-1:0] mg, input logic [W-1:0] mp,
                                           input logic [W-1:0] me);
        longint unsigned acc, base, m;
        if (mp <= 1) return '0;
        m    = longint'(mp);
        acc  = 1;
        base = longint'(mg) % m;
        for (int i = 0; i < W; i++) begin
            if (me[i]) acc = (acc * base) % m;
            base = (base * base) % m;
        end
        return acc[W-1:0];
    endfunction
`endif

    initial begin
        logic [W-1:0] res;
        logic         rerr;
        int           cyc;
        int           done_seen;

        tests = 0;
        fails = 0;

        vecs[0] = '{g: 32'd5,          p: 32'd23,         e: 32'd6,  r: 32'd8,  err: 1'b0};
        vecs[1] = '{g: 32'd5,          p: 32'd23,         e: 32'd15, r: 32'd19, err: 1'b0};
        vecs[2] = '{g: 32'd19,         p: 32'd23,         e: 32'd6,  r: 32'd2,  err: 1'b0};
        vecs[3] = '{g: 32'd8,          p: 32'd23,         e: 32'd15, r: 32'd2,  err: 1'b0};
        vecs[4] = '{g: 32'd30,         p: 32'd23,         e: 32'd1,  r: 32'd7,  err: 1'b0};
        vecs[5] = '{g: 32'd5,          p: 32'd23,         e: 32'd0,  r: 32'd1,  err: 1'b0};
        vecs[6] = '{g: 32'd7,          p: 32'd1,          e: 32'd5,  r: 32'd0,  err: 1'b0};
        vecs[7] = '{g: 32'd7,          p: 32'd0,          e: 32'd5,  r: 32'd0,  err: 1'b1};
        vecs[8] = '{g: 32'd2,          p: 32'hFFFFFFFB,   e: 32'd32, r: 32'd5,  err: 1'b0};
        vecs[9] = '{g: 32'hFFFFFFFF,   p: 32'hFFFFFFFB,   e: 32'd2,  r: 32'd16, err: 1'b0};

        rst = 1'b0;
        st  = 1'b0;
        g   = '0;
        p   = '0;
        e   = '0;
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_r", r, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run(vecs[i].g, vecs[i].p, vecs[i].e, 1'b0, res, rerr, cyc);
            check($sformatf("vec%0d_r", i), res, vecs[i].r);
            check($sformatf("vec%0d_err", i), {31'd0, rerr}, {31'd0, vecs[i].err});
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
            check($sformatf("vec%0d_err_held", i), {31'd0, err}, {31'd0, vecs[i].err});
            check($sformatf("vec%0d_r_held", i), r, vecs[i].r);
        end

        // st re-pulsed while busy must not disturb the running computation
        run(32'd5, 32'd23, 32'd15, 1'b1, res, rerr, cyc);
        check("mid_st_r", res, 32'd19);
        repeat (3) @(negedge clk);
        check("mid_st_no_restart", {31'd0, busy}, 32'd0);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        g  = 32'd5;
        p  = 32'd23;
        e  = 32'd6;
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        repeat (50) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_r", r, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        done_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("rst_no_done", done_seen, 32'd0);
        run(32'd5, 32'd23, 32'd6, 1'b0, res, rerr, cyc);
        check("post_rst_r", res, 32'd8);
        check("post_rst_err", {31'd0, rerr}, 32'd0);

`ifdef MODEXP_CT_EN
        begin
            int c_ref;
            run(32'd5, 32'd23, 32'd1, 1'b0, res, rerr, c_ref);
            check("ct_e1_r", res, 32'd5);
            run(32'd5, 32'd23, 32'hFFFFFFFF, 1'b0, res, rerr, cyc);
            check("ct_emax_r", res, 32'd10);
            check("ct_emax_model", res, model(32'd5, 32'd23, 32'hFFFFFFFF));
            check("ct_emax_cycles", cyc, c_ref);
            run(32'd5, 32'd23, 32'd0, 1'b0, res, rerr, cyc);
            check("ct_e0_r", res, 32'd1);
            check("ct_e0_cycles", cyc, c_ref);
            run(32'd7, 32'd1, 32'd5, 1'b0, res, rerr, cyc);
            check("ct_p1_r", res, 32'd0);
            check("ct_p1_cycles", cyc, c_ref);
            run(32'd7, 32'd0, 32'd5, 1'b0, res, rerr, cyc);
            check("ct_p0_err", {31'd0, rerr}, 32'd1);
            check("ct_p0_cycles", cyc, c_ref);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
